// File: rtl/imem_loader.sv
// Streams a big-endian byte program into instruction memory, one 32-bit word per WRITE cycle,
// and holds the CPU pipeline frozen until the whole image has been written.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] req_bytes;
  logic        req_bad;

  assign req_bytes = {22'd0, word_count, 2'b00};
  assign req_bad   = (word_count == 8'd0) || (req_bytes > 32'(MEM_BYTES));

  // NOTE: every _d gets its hold value first so no path through the case leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (req_bad) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_RECV;
            word_cnt_d = word_count;
            word_idx_d = 8'd0;
            byte_idx_d = 2'd0;
            csum_d     = 8'd0;
          end
        end
      end

      S_RECV: begin
        if (in_valid) begin
          csum_d     = csum_q + in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {shift_q[15:0], in_data};
          // The fourth byte completes the word; address and data are registered
          // here so they are stable during WRITE and hold afterwards.
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = {22'd0, word_idx_q, 2'b00};
            wdata_d = {shift_q, in_data};
          end
        end
      end

      S_WRITE: begin
        if (word_idx_q + 8'd1 == word_cnt_q) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + 8'd1;
          state_d    = S_RECV;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= 8'd0;
      word_idx_q <= 8'd0;
      byte_idx_q <= 2'd0;
      shift_q    <= 24'd0;
      csum_q     <= 8'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready  = (state_q == S_RECV);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign cpu_hold  = (state_q != S_DONE);
  assign checksum  = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams with hand-computed words, addresses
// and checksums, plus error, reset-abort and restart scenarios.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  checksum;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.MEM_BYTES(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sync();
    sync();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] wc);
    start      = 1'b1;
    word_count = wc;
    sync();
    start = 1'b0;
  endtask

  // Presents one byte and holds it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    sync();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      repeat (gap) sync();
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (done || err) ok = 1'b1;
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    sync();
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    word_count = 8'd0;
    in_valid   = 1'b0;
    in_data    = 8'h00;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_addr",     mem_addr,      32'd0);
    check("rst_wdata",    mem_wdata,     32'd0);
    check("rst_flags",    {29'd0, busy, done, err}, 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    sync();

    // Single word, back-to-back bytes, one-cycle write latency
    clear_log();
    pulse_start(8'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    @(negedge clk);
    check("w1_lat_we",   32'(mem_we), 32'd1);
    check("w1_lat_hold", {30'd0, cpu_hold, busy}, 32'd3);
    wait_done();
    check("w1_nwr",     32'(wr_addr.size()), 32'd1);
    check("w1_addr",    wr_addr[0], 32'h0);
    check("w1_data",    wr_data[0], 32'h12345678);
    check("w1_csum",    32'(checksum), 32'h14);
    check("w1_done",    32'(done), 32'd1);
    check("w1_cpuhold", 32'(cpu_hold), 32'd0);

    // Three words with in_valid toggling; start taken from DONE
    clear_log();
    pulse_start(8'd3);
    @(negedge clk);
    check("w3_hold_rises", {30'd0, cpu_hold, busy}, 32'd3);
    check("w3_done_drop",  32'(done), 32'd0);
    sync();
    send_word(32'hA1B2C3D4, 1);
    send_word(32'h01020304, 1);
    send_word(32'hDEADBEEF, 1);
    wait_done();
    check("w3_nwr",   32'(wr_addr.size()), 32'd3);
    check("w3_addr0", wr_addr[0], 32'h0);
    check("w3_data0", wr_data[0], 32'hA1B2C3D4);
    check("w3_addr1", wr_addr[1], 32'h4);
    check("w3_data1", wr_data[1], 32'h01020304);
    check("w3_addr2", wr_addr[2], 32'h8);
    check("w3_data2", wr_data[2], 32'hDEADBEEF);
    check("w3_csum",  32'(checksum), 32'h2C);

    // Illegal word counts go to ERR without writing
    clear_log();
    pulse_start(8'd0);
    @(negedge clk);
    check("wc0_err",  {29'd0, err, done, busy}, 32'd4);
    check("wc0_hold", 32'(cpu_hold), 32'd1);
    do_reset();
    pulse_start(8'd65);
    @(negedge clk);
    check("wc65_err",  {29'd0, err, done, busy}, 32'd4);
    check("wc65_hold", 32'(cpu_hold), 32'd1);
    sync();
    sync();
    check("wc65_persist", 32'(err), 32'd1);
    pulse_start(8'd64);
    @(negedge clk);
    check("wc64_ok", {29'd0, err, done, busy}, 32'd1);
    repeat (4) sync();
    check("err_nwr", 32'(wr_addr.size()), 32'd0);

    // Reset in the middle of word 1 aborts without a write
    do_reset();
    clear_log();
    pulse_start(8'd2);
    send_word(32'h11223344, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("abort_flags", {29'd0, busy, done, err}, 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_csum",  32'(checksum), 32'd0);
    check("abort_hold",  32'(cpu_hold), 32'd1);
    repeat (4) sync();
    check("abort_nwr",   32'(wr_addr.size()), 32'd1);
    check("abort_data0", wr_data[0], 32'h11223344);
    clear_log();
    pulse_start(8'd1);
    send_word(32'h0A0B0C0D, 0);
    wait_done();
    check("reload_nwr",  32'(wr_addr.size()), 32'd1);
    check("reload_addr", wr_addr[0], 32'h0);
    check("reload_data", wr_data[0], 32'h0A0B0C0D);
    check("reload_csum", 32'(checksum), 32'h2E);

    // Start pulsed during RECV is ignored
    clear_log();
    pulse_start(8'd2);
    send_byte(8'hCA);
    send_byte(8'hFE);
    pulse_start(8'd1);
    send_byte(8'hBA);
    send_byte(8'hBE);
    send_word(32'h13579BDF, 0);
    wait_done();
    check("ign_nwr",   32'(wr_addr.size()), 32'd2);
    check("ign_addr0", wr_addr[0], 32'h0);
    check("ign_data0", wr_data[0], 32'hCAFEBABE);
    check("ign_addr1", wr_addr[1], 32'h4);
    check("ign_data1", wr_data[1], 32'h13579BDF);
    check("ign_csum",  32'(checksum), 32'h24);

    // Checksum wrap with all-ones bytes
    clear_log();
    pulse_start(8'd2);
    send_word(32'hFFFFFFFF, 0);
    send_word(32'hFFFFFFFF, 0);
    wait_done();
    check("ff_nwr",   32'(wr_addr.size()), 32'd2);
    check("ff_addr0", wr_addr[0], 32'h0);
    check("ff_data0", wr_data[0], 32'hFFFFFFFF);
    check("ff_addr1", wr_addr[1], 32'h4);
    check("ff_data1", wr_data[1], 32'hFFFFFFFF);
    check("ff_csum",  32'(checksum), 32'hF8);
    repeat (3) sync();
    check("ff_hold_addr",  mem_addr, 32'h4);
    check("ff_hold_wdata", mem_wdata, 32'hFFFFFFFF);
    check("ff_done_persist", {30'd0, done, mem_we}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
